// File: rtl/traffic_req_conditioner.sv
// Request conditioning for the intersection controller: synchronise, debounce and
// latch raw loop/button inputs as pending requests, flagging presses lost to a busy channel.
module traffic_req_conditioner #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DEBOUNCE_CYC = 8,
    parameter int unsigned ID_W         = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sensor_in,
    input  logic [N_CH-1:0] req_ack,
    input  logic            clr_err,
    output logic [N_CH-1:0] req_pending,
    output logic            req_valid,
    output logic [ID_W-1:0] req_id,
    output logic [N_CH-1:0] db_state,
    output logic [N_CH-1:0] err_drop
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYC - 1);

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] db_q;
    logic [N_CH-1:0] db_d;
    logic [7:0]      cnt_q [N_CH];
    logic [7:0]      cnt_d [N_CH];
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_d;
    logic [N_CH-1:0] err_q;
    logic [N_CH-1:0] err_d;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            pend_q  <= '0;
            err_q   <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sensor_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        db_d   = db_q;
        pend_d = pend_q;
        rise   = '0;
        drop   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
                rise[i]  = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end

            // A rise coinciding with an ack is a fresh request, not a lost one.
            if (rise[i] && pend_q[i] && !req_ack[i]) begin
                drop[i] = 1'b1;
            end else if (rise[i]) begin
                pend_d[i] = 1'b1;
            end else if (req_ack[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        err_d = (clr_err ? '0 : err_q) | drop;
    end

    always_comb begin
        req_id = '0;
        for (int unsigned i = N_CH; i > 0; i--) begin
            if (pend_q[i-1]) begin
                req_id = ID_W'(i - 1);
            end
        end
    end

    assign req_pending = pend_q;
    assign req_valid   = |pend_q;
    assign db_state    = db_q;
    assign err_drop    = err_q;

endmodule
